// File: rtl/t_ff_mod_counter.sv
// -----------------------------------------------------------------------------
// t_ff_mod_counter
//   Parametrised modulo-N up/down counter whose state lives in a bank of
//   toggle flip-flops: every bit updates as q[i] <= q[i] ^ t_vec[i], where the
//   toggle vector is derived from the desired next count (t_vec = q ^ q_next).
//   Supports synchronous clear, parallel load with clamping, count enable,
//   direction control, wrap or saturate behaviour at the range ends, a
//   combinational terminal-count flag and a registered overflow pulse.
// -----------------------------------------------------------------------------
module t_ff_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    // Upper end of the count range as a WIDTH-bit constant; a modulus of
    // 2**WIDTH yields all-ones and therefore natural binary wrap.
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Reject illegal moduli at elaboration time.
    generate
        if ((MOD < 2) || (longint'(MOD) > (longint'(1) << WIDTH))) begin : g_bad_mod
            $error("t_ff_mod_counter: MOD must lie in 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] t_vec_s;
    logic             ovf_r;
    logic             ovf_next_s;
    logic             tc_s;

    // Next-count selection with priority CLR > LD > EN > hold.
    always_comb begin
        q_next_s   = q_r;
        ovf_next_s = 1'b0;
        if (CLR) begin
            q_next_s = ZERO_C;
        end else if (LD) begin
            // D < MOD is the same as D <= MOD-1 at WIDTH bits, even for MOD == 2**WIDTH.
            if (D > MAX_C) begin
                q_next_s = MAX_C;
            end else begin
                q_next_s = D;
            end
        end else if (EN) begin
            if (q_r > MAX_C) begin
                // Corrupted state: snap to the end of the range we are heading from.
                q_next_s   = UP ? ZERO_C : MAX_C;
                ovf_next_s = 1'b1;
            end else if (UP) begin
                if (q_r == MAX_C) begin
                    q_next_s   = (SATURATE != 0) ? q_r : ZERO_C;
                    ovf_next_s = 1'b1;
                end else begin
                    q_next_s = q_r + ONE_C;
                end
            end else begin
                if (q_r == ZERO_C) begin
                    q_next_s   = (SATURATE != 0) ? q_r : MAX_C;
                    ovf_next_s = 1'b1;
                end else begin
                    q_next_s = q_r - ONE_C;
                end
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Toggle vector: the bits that must flip to reach the next count.
    always_comb begin
        t_vec_s = q_r ^ q_next_s;
    end

    // Terminal count: an enabled, unblocked count sits at the range end it is moving toward.
    always_comb begin
        tc_s = EN & ~CLR & ~LD &
               ((UP & (q_r == MAX_C)) | (~UP & (q_r == ZERO_C)));
    end

    // Toggle flip-flop bank and overflow pulse register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_r   <= ZERO_C;
            ovf_r <= 1'b0;
        end else begin
            q_r   <= q_r ^ t_vec_s;
            ovf_r <= ovf_next_s;
        end
    end

    assign Q   = q_r;
    assign OVF = ovf_r;
    assign TC  = tc_s;

endmodule

// File: tb/tb_t_ff_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_t_ff_mod_counter
//   Directed self-checking bench. Three instances:
//     dut      WIDTH=4 MOD=10 SATURATE=0
//     dut_sat  WIDTH=4 MOD=10 SATURATE=1
//     dut_full WIDTH=3 MOD=8  SATURATE=0
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_t_ff_mod_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       clr = 1'b0, ld = 1'b0, en = 1'b0, up = 1'b0;
    logic [3:0] d   = 4'd0;
    logic [3:0] q;
    logic       tc, ovf;

    logic       s_clr = 1'b0, s_ld = 1'b0, s_en = 1'b0, s_up = 1'b0;
    logic [3:0] s_d   = 4'd0;
    logic [3:0] s_q;
    logic       s_tc, s_ovf;

    logic       f_clr = 1'b0, f_ld = 1'b0, f_en = 1'b0, f_up = 1'b0;
    logic [2:0] f_d   = 3'd0;
    logic [2:0] f_q;
    logic       f_tc, f_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    t_ff_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) dut (
        .CLK(clk), .RST(rst), .CLR(clr), .LD(ld), .D(d), .EN(en), .UP(up),
        .Q(q), .TC(tc), .OVF(ovf)
    );

    t_ff_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) dut_sat (
        .CLK(clk), .RST(rst), .CLR(s_clr), .LD(s_ld), .D(s_d), .EN(s_en), .UP(s_up),
        .Q(s_q), .TC(s_tc), .OVF(s_ovf)
    );

    t_ff_mod_counter #(.WIDTH(3), .MOD(8), .SATURATE(0)) dut_full (
        .CLK(clk), .RST(rst), .CLR(f_clr), .LD(f_ld), .D(f_d), .EN(f_en), .UP(f_up),
        .Q(f_q), .TC(f_tc), .OVF(f_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        total_cnt++;
        if (q !== 4'd0 || ovf !== 1'b0 || tc !== 1'b0) $display("FAIL reset_init: q=%0d ovf=%b tc=%b required q=0 ovf=0 tc=0", q, ovf, tc);
        else pass_cnt++;
        tick();
        rst = 1'b1;
        ld = 1'b1; d = 4'd7;
        tick();
        ld = 1'b0;
        total_cnt++;
        if (q !== 4'd7) $display("FAIL reset_load7: q=%0d required 7", q);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (q !== 4'd0 || ovf !== 1'b0) $display("FAIL reset_async: q=%0d ovf=%b required q=0 ovf=0", q, ovf);
        else pass_cnt++;
        en = 1'b1; up = 1'b1;
        tick();
        total_cnt++;
        if (q !== 4'd0) $display("FAIL reset_held: q=%0d required 0", q);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (q !== 4'd1) $display("FAIL reset_release: q=%0d required 1", q);
        else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_up_wrap();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total_cnt++;
        if (q !== 4'd0) $display("FAIL upwrap_clear: q=%0d required 0", q);
        else pass_cnt++;
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            total_cnt++;
            if (tc !== (((k - 1) % 10) == 9)) $display("FAIL upwrap_tc edge %0d: tc=%b required %b", k, tc, (((k - 1) % 10) == 9));
            else pass_cnt++;
            tick();
            total_cnt++;
            if (q !== 4'(k % 10)) $display("FAIL upwrap_q edge %0d: q=%0d required %0d", k, q, k % 10);
            else pass_cnt++;
            total_cnt++;
            if (ovf !== (k == 10)) $display("FAIL upwrap_ovf edge %0d: ovf=%b required %b", k, ovf, (k == 10));
            else pass_cnt++;
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_q [4];
        exp_q[0] = 4'd1; exp_q[1] = 4'd0; exp_q[2] = 4'd9; exp_q[3] = 4'd8;
        ld = 1'b1; d = 4'd2;
        tick();
        ld = 1'b0;
        total_cnt++;
        if (q !== 4'd2 || ovf !== 1'b0) $display("FAIL down_load: q=%0d ovf=%b required q=2 ovf=0", q, ovf);
        else pass_cnt++;
        en = 1'b1; up = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (tc !== (k == 2)) $display("FAIL down_tc step %0d: tc=%b required %b", k, tc, (k == 2));
            else pass_cnt++;
            tick();
            total_cnt++;
            if (q !== exp_q[k]) $display("FAIL down_q step %0d: q=%0d required %0d", k, q, exp_q[k]);
            else pass_cnt++;
            total_cnt++;
            if (ovf !== (k == 2)) $display("FAIL down_ovf step %0d: ovf=%b required %b", k, ovf, (k == 2));
            else pass_cnt++;
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        s_ld = 1'b1; s_d = 4'd8;
        tick();
        s_ld = 1'b0;
        s_en = 1'b1; s_up = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if (s_q !== 4'd9 || s_ovf !== (k > 0)) $display("FAIL sat_up step %0d: q=%0d ovf=%b required q=9 ovf=%b", k, s_q, s_ovf, (k > 0));
            else pass_cnt++;
        end
        s_up = 1'b0;
        tick();
        total_cnt++;
        if (s_q !== 4'd8 || s_ovf !== 1'b0) $display("FAIL sat_down: q=%0d ovf=%b required q=8 ovf=0", s_q, s_ovf);
        else pass_cnt++;
        s_en = 1'b0;
    endtask

    task automatic test_priority();
        ld = 1'b1; d = 4'd5;
        tick();
        total_cnt++;
        if (q !== 4'd5) $display("FAIL prio_load5: q=%0d required 5", q);
        else pass_cnt++;
        clr = 1'b1; ld = 1'b1; en = 1'b1; up = 1'b1; d = 4'd3;
        tick();
        total_cnt++;
        if (q !== 4'd0 || ovf !== 1'b0) $display("FAIL prio_clr: q=%0d ovf=%b required q=0 ovf=0", q, ovf);
        else pass_cnt++;
        clr = 1'b0; d = 4'd13;
        tick();
        total_cnt++;
        if (q !== 4'd9 || ovf !== 1'b0) $display("FAIL prio_clamp: q=%0d ovf=%b required q=9 ovf=0", q, ovf);
        else pass_cnt++;
        total_cnt++;
        if (tc !== 1'b0) $display("FAIL prio_tc_ld: tc=%b required 0", tc);
        else pass_cnt++;
        ld = 1'b0; en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if (q !== 4'd9 || tc !== 1'b0 || ovf !== 1'b0) $display("FAIL prio_hold step %0d: q=%0d tc=%b ovf=%b required q=9 tc=0 ovf=0", k, q, tc, ovf);
            else pass_cnt++;
        end
        en = 1'b1;
        #1;
        total_cnt++;
        if (tc !== 1'b1) $display("FAIL prio_tc_en: tc=%b required 1", tc);
        else pass_cnt++;
        en = 1'b0;
    endtask

    task automatic test_full_range();
        logic [2:0] prev_q;
        f_clr = 1'b1;
        tick();
        f_clr = 1'b0;
        total_cnt++;
        if (f_q !== 3'd0) $display("FAIL full_clear: q=%0d required 0", f_q);
        else pass_cnt++;
        f_en = 1'b1; f_up = 1'b1;
        prev_q = f_q;
        for (int k = 1; k <= 9; k++) begin
            tick();
            total_cnt++;
            if ((prev_q ^ f_q) !== (3'((k - 1) % 8) ^ 3'(k % 8))) $display("FAIL full_tvec edge %0d: toggled=%b required %b", k, prev_q ^ f_q, 3'((k - 1) % 8) ^ 3'(k % 8));
            else pass_cnt++;
            total_cnt++;
            if (f_q !== 3'(k % 8)) $display("FAIL full_q edge %0d: q=%0d required %0d", k, f_q, k % 8);
            else pass_cnt++;
            total_cnt++;
            if (f_ovf !== (k == 8)) $display("FAIL full_ovf edge %0d: ovf=%b required %b", k, f_ovf, (k == 8));
            else pass_cnt++;
            prev_q = f_q;
        end
        f_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_priority();
        test_full_range();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
